// File: rtl/cut_io_shifter.sv
// SPI mode-0 serial shifter toward the circuit-under-test.
// Bit timing comes from div_clk edges observed in the clk domain.
module cut_io_shifter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_clk,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             cs_n,
    output logic             sclk,
    output logic             sdo,
    input  logic             sdi
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ALIGN,
        SHIFT,
        DONE
    } state_e;

    state_e           state_q;
    logic             div_q;
    logic [WIDTH-1:0] tx_sh_q;
    logic [WIDTH-1:0] rx_sh_q;
    logic [WIDTH-1:0] rx_data_q;
    logic [CW-1:0]    bit_cnt_q;
    logic             tx_ready_q;
    logic             rx_valid_q;
    logic             cs_n_q;
    logic             sclk_q;
    logic             sdo_q;

    logic rise;
    logic fall;

    assign rise = div_clk & ~div_q;
    assign fall = ~div_clk & div_q;

    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign cs_n     = cs_n_q;
    assign sclk     = sclk_q;
    assign sdo      = sdo_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            div_q      <= 1'b0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            bit_cnt_q  <= '0;
            tx_ready_q <= 1'b1;
            rx_valid_q <= 1'b0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            sdo_q      <= 1'b0;
        end else begin
            div_q      <= div_clk;
            rx_valid_q <= 1'b0;
            // sclk follows div_clk one clk late, only while shifting
            sclk_q     <= (state_q == SHIFT) ? div_clk : 1'b0;
            case (state_q)
                IDLE: begin
                    if (tx_valid && tx_ready_q) begin
                        tx_sh_q    <= tx_data;
                        bit_cnt_q  <= '0;
                        tx_ready_q <= 1'b0;
                        state_q    <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (fall) begin
                        cs_n_q  <= 1'b0;
                        sdo_q   <= tx_sh_q[WIDTH-1];
                        tx_sh_q <= {tx_sh_q[WIDTH-2:0], 1'b0};
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (rise) begin
                        rx_sh_q   <= {rx_sh_q[WIDTH-2:0], sdi};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST) begin
                            state_q <= DONE;
                        end
                    end
                    if (fall) begin
                        sdo_q   <= tx_sh_q[WIDTH-1];
                        tx_sh_q <= {tx_sh_q[WIDTH-2:0], 1'b0};
                    end
                end
                DONE: begin
                    if (fall) begin
                        cs_n_q     <= 1'b1;
                        sdo_q      <= 1'b0;
                        rx_data_q  <= rx_sh_q;
                        rx_valid_q <= 1'b1;
                        tx_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cut_io_shifter.sv
// Scoreboard bench for cut_io_shifter: stimulus pushes expectations,
// a negedge monitor pops them on frame end and on rx_valid.
module tb_cut_io_shifter;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         div_clk;
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         cs_n;
    logic         sclk;
    logic         sdo;
    logic         sdi;

    int errors = 0;
    int checks = 0;
    int sdi_mode = 0;
    int half = 1;
    int chk_period = 1;
    int rx_cnt = 0;
    int nbits = 0;

    logic [W-1:0] exp_tx[$];
    logic [W-1:0] exp_rx[$];

    cut_io_shifter #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .div_clk (div_clk),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .cs_n    (cs_n),
        .sclk    (sclk),
        .sdo     (sdo),
        .sdi     (sdi)
    );

    // sdi source: 0 loopback, 1 inverted loopback, 2 tied high, 3 tied low
    assign sdi = (sdi_mode == 0) ? sdo :
                 (sdi_mode == 1) ? ~sdo :
                 (sdi_mode == 2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        int dcnt;
        dcnt = 0;
        div_clk = 1'b0;
        forever begin
            @(negedge clk);
            if (half > 0) begin
                dcnt++;
                if (dcnt >= half) begin
                    div_clk = ~div_clk;
                    dcnt = 0;
                end
            end
        end
    end

    function automatic logic [W-1:0] model_rx(input logic [W-1:0] d,
                                              input int m);
        case (m)
            0:       return d;
            1:       return ~d;
            2:       return '1;
            default: return '0;
        endcase
    endfunction

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string name);
        check({name, ".tx_ready"}, W'(tx_ready), W'(1));
        check({name, ".cs_n"}, W'(cs_n), W'(1));
        check({name, ".sclk"}, W'(sclk), W'(0));
        check({name, ".sdo"}, W'(sdo), W'(0));
        check({name, ".rx_valid"}, W'(rx_valid), W'(0));
        check({name, ".rx_data"}, rx_data, '0);
    endtask

    task automatic send(input logic [W-1:0] d, input int m);
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (tx_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: tx_ready=%b required 1", tx_ready);
        end else begin
            sdi_mode = m;
            tx_data = d;
            tx_valid = 1'b1;
            exp_tx.push_back(d);
            exp_rx.push_back(model_rx(d, m));
            @(negedge clk);
            tx_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if (exp_rx.size() == 0 && tx_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: pending=%0d required 0",
                     exp_rx.size());
            exp_tx.delete();
            exp_rx.delete();
        end
    endtask

    initial begin
        logic         prev_sclk;
        logic         prev_cs;
        logic [W-1:0] bits;
        int           cyc;
        int           last_rise;
        prev_sclk = 1'b0;
        prev_cs = 1'b1;
        bits = '0;
        cyc = 0;
        last_rise = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                nbits = 0;
                prev_sclk = 1'b0;
                prev_cs = 1'b1;
            end else begin
                if (sclk && !prev_sclk) begin
                    if (nbits > 0 && chk_period != 0)
                        check_int("sclk_period", cyc - last_rise, 2 * half);
                    last_rise = cyc;
                    bits = {bits[W-2:0], sdo};
                    nbits++;
                end
                if (cs_n && sclk)
                    check("sclk_idle", W'(sclk), W'(0));
                if (cs_n && !prev_cs) begin
                    check_int("bit_count", nbits, W);
                    if (exp_tx.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sdo_frame: got %h expected none", bits);
                    end else begin
                        check("sdo_frame", bits, exp_tx.pop_front());
                    end
                    nbits = 0;
                end
                if (rx_valid) begin
                    rx_cnt++;
                    check("cs_n_at_rx", W'(cs_n), W'(1));
                    if (exp_rx.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_data: got %h expected none", rx_data);
                    end else begin
                        check("rx_data", rx_data, exp_rx.pop_front());
                    end
                end
                prev_sclk = sclk;
                prev_cs = cs_n;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time=%0t required finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int rxc;
        int nb;
        bit ok;
        rst = 1'b0;
        tx_valid = 1'b0;
        tx_data = '0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset("rst_init");
        @(negedge clk);
        rst = 1'b1;

        send(8'hA5, 0);
        wait_done();
        send(8'h00, 2);
        wait_done();
        send(8'hFF, 3);
        wait_done();

        rxc = rx_cnt;
        send(8'h96, 0);
        repeat (5) @(negedge clk);
        tx_data = 8'h3C;
        tx_valid = 1'b1;
        repeat (4) @(negedge clk);
        tx_valid = 1'b0;
        wait_done();
        check_int("single_rx", rx_cnt - rxc, 1);

        send(8'h81, 0);
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            #1;
            if (nbits >= 3) begin
                ok = 1;
                break;
            end
        end
        check_int("mid_frame_reached", int'(ok), 1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_reset("rst_mid");
        exp_tx.delete();
        exp_rx.delete();
        rxc = rx_cnt;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        check_int("no_rx_after_rst", rx_cnt - rxc, 0);
        send(8'h5A, 0);
        wait_done();

        half = 4;
        send(8'hC3, 0);
        wait_done();
        half = 1;

        chk_period = 0;
        send(8'h6E, 1);
        repeat (8) @(negedge clk);
        half = 0;
        #1;
        nb = nbits;
        repeat (40) @(negedge clk);
        #1;
        check("stall_cs_n", W'(cs_n), W'(0));
        check("stall_tx_ready", W'(tx_ready), W'(0));
        check_int("stall_bits", nbits, nb);
        half = 1;
        wait_done();
        chk_period = 1;

        repeat (24) begin
            half = $urandom_range(1, 3);
            send(W'($urandom), $urandom_range(0, 3));
            wait_done();
        end

        half = 2;
        rxc = rx_cnt;
        repeat (4) send(W'($urandom), 0);
        wait_done();
        check_int("burst_rx", rx_cnt - rxc, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
